// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU accumulate is enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         dz
);

  localparam int unsigned CMAX = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU
  } op_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic            sgn_q, sgn_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            divz_q, divz_d;
`ifdef MULDIV_MADD_EN
  logic            acc_q, acc_d;
`endif

  op_t             op_in;
  logic [2*W-1:0]  ext_a, ext_b, prod, mul_res;
  logic [W:0]      trial;
  logic            ge;
  logic [W-1:0]    rem_next;
  logic [W-1:0]    a_mag, b_mag;

  assign op_in = op_t'(op);

  // Sign- or zero-extension to 2W makes the truncated product correct for both.
  assign ext_a = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
  assign ext_b = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef MULDIV_MADD_EN
  assign mul_res = acc_q ? (prod + {hi_q, lo_q}) : prod;
`else
  assign mul_res = prod;
`endif

  // Restoring step: a_q shifts out dividend bits and collects quotient bits.
  assign trial    = {rem_q, a_q[W-1]};
  assign ge       = (trial >= {1'b0, b_q});
  assign rem_next = ge ? (trial[W-1:0] - b_q) : trial[W-1:0];

  assign a_mag = (op_in == OP_DIV && a[W-1]) ? -a : a;
  assign b_mag = (op_in == OP_DIV && b[W-1]) ? -b : b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    divz_d  = divz_q;
`ifdef MULDIV_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          case (op_in)
            OP_MULT, OP_MULTU: begin
              sgn_d   = (op_in == OP_MULT);
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(MUL_LAT - 1);
              state_d = S_MUL;
`ifdef MULDIV_MADD_EN
              acc_d   = 1'b0;
`endif
            end
            OP_MADD, OP_MADDU: begin
`ifdef MULDIV_MADD_EN
              sgn_d   = (op_in == OP_MADD);
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(MUL_LAT - 1);
              state_d = S_MUL;
              acc_d   = 1'b1;
`else
              done_d  = 1'b1;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                divz_d  = 1'b1;
                state_d = S_FIX;
              end else begin
                divz_d  = 1'b0;
                a_d     = a_mag;
                b_d     = b_mag;
                rem_d   = '0;
                negq_d  = (op_in == OP_DIV) && (a[W-1] ^ b[W-1]);
                negr_d  = (op_in == OP_DIV) && a[W-1];
                cnt_d   = CW'(W - 1);
                state_d = S_DIV;
              end
            end
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        a_d   = {a_q[W-2:0], ge};
        rem_d = rem_next;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (divz_q) begin
          hi_d = '1;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          lo_d = negq_q ? -a_q : a_q;
          hi_d = negr_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
`ifdef MULDIV_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/dz/latency pushed on issue, popped on completion.
module tb_muldiv_unit;
  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, dz;
  logic [W-1:0]  hi, lo;

  muldiv_unit #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          n_cmp = 0, n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Computes the architectural result, pushes it, then drives one start cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    longint      sx, sy, q, r;
    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; e.lat = 0;
    case (o)
      3'd0: begin p = longint'($signed(x)) * longint'($signed(y)); {e.hi, e.lo} = p; e.lat = int'(MUL_LAT); end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; {e.hi, e.lo} = p; e.lat = int'(MUL_LAT); end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          e.hi = '1; e.lo = '1; e.dz = 1'b1; e.lat = 1;
        end else begin
          if (o == 3'd2) begin sx = longint'($signed(x)); sy = longint'($signed(y)); end
          else           begin sx = longint'({32'b0, x}); sy = longint'({32'b0, y}); end
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0]; e.lat = int'(W) + 1;
        end
      end
      3'd4: e.hi = x;
      3'd5: e.lo = x;
      default: begin
`ifdef MULDIV_MADD_EN
        if (o == 3'd6) p = longint'($signed(x)) * longint'($signed(y));
        else           p = {32'b0, x} * {32'b0, y};
        {e.hi, e.lo} = p + {m_hi, m_lo};
        e.lat = int'(MUL_LAT);
`endif
      end
    endcase
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    n_cmp++;
    if ({busy, done, dz, hi, lo} !== '0) begin
      n_bad++;
      $display("FAIL reset got busy=%b done=%b dz=%b hi=%h lo=%h want all zero", busy, done, dz, hi, lo);
    end
  endtask

  task automatic test_mult();
    int cyc; exp_t e; logic [73:0] got, want;
    logic [2:0] ot[6]; logic [31:0] xt[6], yt[6];
    ot = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    xt = '{32'hFFFF_FFFD, 32'h0000_0000, $urandom, $urandom, 32'h8000_0000, $urandom};
    yt = '{32'h0000_0005, 32'h1234_5678, $urandom, $urandom, 32'h8000_0000, $urandom};
    for (int i = 0; i < 6; i++) begin
      issue(ot[i], xt[i], yt[i]);
      wait_idle(cyc);
      e = sb.pop_front();
      got  = {8'(cyc), done, dz, hi, lo};
      want = {8'(e.lat), 1'b1, e.dz, e.hi, e.lo};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL mult[%0d] got cyc/done/dz/hi/lo=%h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; exp_t e; logic [73:0] got, want;
    logic [2:0] ot[3]; logic [31:0] xt[3], yt[3];
    ot = '{3'd1, 3'd5, 3'd0};
    xt = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0007};
    yt = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFA};
    for (int i = 0; i < 3; i++) begin
      issue(ot[i], xt[i], yt[i]);
      if (i == 2) begin
        n_cmp++;
        if ({done, busy} !== 2'b01) begin
          n_bad++;
          $display("FAIL b2b_mult_accept got done=%b busy=%b want done=0 busy=1", done, busy);
        end
      end
      wait_idle(cyc);
      e = sb.pop_front();
      got  = {8'(cyc), done, dz, hi, lo};
      want = {8'(e.lat), 1'b1, e.dz, e.hi, e.lo};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL b2b[%0d] got cyc/done/dz/hi/lo=%h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_div();
    int cyc; exp_t e; logic [73:0] got, want;
    logic [2:0] ot[8]; logic [31:0] xt[8], yt[8];
    ot = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3};
    xt = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, $urandom, $urandom, $urandom};
    yt = '{32'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, $urandom | 32'd1, $urandom | 32'd1,
           $urandom_range(1, 1000)};
    for (int i = 0; i < 8; i++) begin
      issue(ot[i], xt[i], yt[i]);
      wait_idle(cyc);
      e = sb.pop_front();
      got  = {8'(cyc), done, dz, hi, lo};
      want = {8'(e.lat), 1'b1, e.dz, e.hi, e.lo};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL div[%0d] got cyc/done/dz/hi/lo=%h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc; exp_t e; logic [73:0] got, want;
    logic [2:0] ot[2]; logic [31:0] xt[2];
    ot = '{3'd3, 3'd4};
    xt = '{32'd10, 32'h0000_ABCD};
    for (int i = 0; i < 2; i++) begin
      issue(ot[i], xt[i], 32'd0);
      wait_idle(cyc);
      e = sb.pop_front();
      got  = {8'(cyc), done, dz, hi, lo};
      want = {8'(e.lat), 1'b1, e.dz, e.hi, e.lo};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL divzero[%0d] got cyc/done/dz/hi/lo=%h want %h", i, got, want);
      end
      if (i == 0) begin
        tick(); tick(); tick();
        n_cmp++;
        if (dz !== 1'b1) begin
          n_bad++;
          $display("FAIL dz_sticky got dz=%b want 1", dz);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; exp_t e; logic [73:0] got, want;
    issue(3'd3, 32'd100, 32'd7);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin
      if (cyc == 5) begin start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; end
      if (cyc == 6) start = 1'b0;
      cyc++;
      tick();
    end
    start = 1'b0;
    e = sb.pop_front();
    got  = {8'(cyc), done, dz, hi, lo};
    want = {8'(e.lat), 1'b1, e.dz, e.hi, e.lo};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL busy_ignore got cyc/done/dz/hi/lo=%h want %h", got, want);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL busy_ignore_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0;
    n_cmp++;
    if ({busy, done, dz, hi, lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_abort got busy=%b done=%b dz=%b hi=%h lo=%h want all zero", busy, done, dz, hi, lo);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_abort_done got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_madd();
    int cyc; exp_t e; logic [73:0] got, want;
    logic [2:0] ot[5]; logic [31:0] xt[5], yt[5];
    ot = '{3'd4, 3'd5, 3'd7, 3'd6, 3'd7};
    xt = '{32'h0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    yt = '{32'h0, 32'h0, 32'd1, 32'd3, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      issue(ot[i], xt[i], yt[i]);
      wait_idle(cyc);
      e = sb.pop_front();
      got  = {8'(cyc), done, dz, hi, lo};
      want = {8'(e.lat), 1'b1, e.dz, e.hi, e.lo};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL madd[%0d] got cyc/done/dz/hi/lo=%h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_madd();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
